// File: rtl/source_operand.sv
// Second-source operand former.
// The operand is selected combinationally from the register value R, the
// immediate field Imm and the select code IS, then registered into N.
// The block has no enable, no handshake and no state machine. N takes the
// selection of the inputs present at each rising clk edge, so the latency is
// exactly one clock. N clears asynchronously while rst_n is low.
module source_operand (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] R,
  input  logic [21:0] Imm,
  input  logic [3:0]  IS,
  output logic [31:0] N
);

  // Candidate operand forms, each built from only the bits it names.
  logic [31:0] sethi_val;   // imm22 placed in the upper bits, low ten cleared
  logic [31:0] disp22_val;  // imm22 sign-extended from Imm[21]
  logic [31:0] simm13_val;  // simm13 sign-extended from Imm[12]; Imm[21:13] ignored
  logic [31:0] rshamt_val;  // shift count taken from R[4:0]
  logic [31:0] ishamt_val;  // shift count taken from Imm[4:0]
  logic [31:0] next_n;

  // Build every candidate form in parallel.
  always_comb begin
    sethi_val  = {Imm[21:0], 10'b0};
    disp22_val = {{10{Imm[21]}}, Imm[21:0]};
    simm13_val = {{19{Imm[12]}}, Imm[12:0]};
    rshamt_val = {27'b0, R[4:0]};
    ishamt_val = {27'b0, Imm[4:0]};
  end

  // Choose one candidate form. Every IS code maps to a defined form.
  always_comb begin
    next_n = R;
    casez (IS)
      4'b00??: next_n = sethi_val;
      4'b01??: next_n = disp22_val;
      4'b1000: next_n = R;
      4'b1001: next_n = simm13_val;
      4'b1010: next_n = rshamt_val;
      4'b1011: next_n = ishamt_val;
      4'b11?0: next_n = R;
      4'b11?1: next_n = simm13_val;
      default: next_n = R;
    endcase
  end

  // Register the selected operand every cycle. An asynchronous reset clears
  // N and discards any pending selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      N <= 32'h0000_0000;
    end else begin
      N <= next_n;
    end
  end

endmodule

// File: tb/tb_source_operand.sv
// Bench for source_operand: directed vectors with hand-computed results,
// latency and asynchronous-reset scenarios, and a sweep of all IS codes
// checked against an independent reference model.
module tb_source_operand;

  logic        clk;
  logic        rst_n;
  logic [31:0] R;
  logic [21:0] Imm;
  logic [3:0]  IS;
  logic [31:0] N;

  int total_checks  = 0;
  int passed_checks = 0;

  logic [31:0] exp_q[$];

  source_operand dut (
    .clk  (clk),
    .rst_n(rst_n),
    .R    (R),
    .Imm  (Imm),
    .IS   (IS),
    .N    (N)
  );

  // Clock: 10 time-unit period. Rising edges occur at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model. It is written arithmetically rather than as a case table.
  function automatic logic [31:0] ref_sel(input logic [31:0] r, input logic [21:0] imm,
                                          input logic [3:0] is);
    logic signed [21:0] s22;
    logic signed [12:0] s13;
    logic signed [31:0] ext;
    s22 = imm;
    s13 = imm[12:0];
    if (is[3] == 1'b0) begin
      if (is[2] == 1'b0) begin
        ref_sel = 32'(imm) << 10;
      end else begin
        ext = s22;
        ref_sel = ext;
      end
    end else if (is[3:2] == 2'b10 && is[1] == 1'b1) begin
      ref_sel = (is[0] ? 32'(imm) : r) & 32'h1F;
    end else begin
      ext = s13;
      ref_sel = is[0] ? ext : r;
    end
  endfunction

  // Drive one input set at the falling edge and push its expected result.
  task automatic drive(input logic [31:0] r, input logic [21:0] imm, input logic [3:0] is,
                       input logic [31:0] exp);
    @(negedge clk);
    R   = r;
    Imm = imm;
    IS  = is;
    exp_q.push_back(exp);
  endtask

  // Wait past the next rising edge, then compare N with the oldest expected value.
  task automatic sample(input string tag);
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_noexp"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check(tag, N, e);
    end
  endtask

  typedef struct {
    logic [31:0] r;
    logic [21:0] imm;
    logic [3:0]  is;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rr;
    logic [21:0] ii;

    // Reset held from time 0 while the inputs are non-zero.
    rst_n = 1'b0;
    R     = 32'hE000_0003;
    Imm   = 22'h231113;
    IS    = 4'b0000;
    #12;
    check("reset_hold", N, 32'h0);

    // Release reset between edges. N must stay 0 until the next rising edge.
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_release", N, 32'h0);
    @(posedge clk);
    #1;
    check("first_edge", N, 32'h8C44_4C00);

    // Directed vectors with hand-computed results.
    for (int c = 0; c < 4; c++) vecs.push_back('{32'hE000_0003, 22'h231113, 4'(c),     32'h8C44_4C00});
    for (int c = 4; c < 8; c++) vecs.push_back('{32'hE000_0003, 22'h231113, 4'(c),     32'hFFE3_1113});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1000, 32'hE000_0003});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1100, 32'hE000_0003});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1110, 32'hE000_0003});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1001, 32'hFFFF_F113});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1101, 32'hFFFF_F113});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1111, 32'hFFFF_F113});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1010, 32'h0000_0003});
    vecs.push_back('{32'hE000_0003, 22'h231113, 4'b1011, 32'h0000_0013});
    vecs.push_back('{32'hE000_0003, 22'h230113, 4'b1001, 32'h0000_0113});
    vecs.push_back('{32'hE000_0003, 22'h230113, 4'b1101, 32'h0000_0113});
    vecs.push_back('{32'hE000_0003, 22'h230113, 4'b1111, 32'h0000_0113});
    vecs.push_back('{32'hE000_0003, 22'h230113, 4'b1011, 32'h0000_0013});
    vecs.push_back('{32'hE000_0003, 22'h230113, 4'b1000, 32'hE000_0003});
    // The upper bits of R and Imm must not leak into the shift counts.
    vecs.push_back('{32'hFFFF_FFE5, 22'h3FFFEA, 4'b1010, 32'h0000_0005});
    vecs.push_back('{32'hFFFF_FFE5, 22'h3FFFEA, 4'b1011, 32'h0000_000A});
    // Imm[21:13] must not affect simm13.
    vecs.push_back('{32'h1234_5678, 22'h3FE000 | 22'h0ABC, 4'b1001, 32'h0000_0ABC});

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].imm, vecs[k].is, vecs[k].exp);
      sample($sformatf("vec%0d_is%b", k, vecs[k].is));
    end

    // Latency: change IS from 1000 to 1011 between edges. N changes only at the edge.
    drive(32'hE000_0003, 22'h231113, 4'b1000, 32'hE000_0003);
    sample("lat_before");
    @(negedge clk);
    IS = 4'b1011;
    #1;
    check("lat_hold", N, 32'hE000_0003);
    @(posedge clk);
    #1;
    check("lat_after", N, 32'h0000_0013);

    // Mid-operation reset between edges, followed by a release.
    drive(32'hE000_0003, 22'h231113, 4'b0000, 32'h8C44_4C00);
    sample("pre_reset");
    @(negedge clk);
    IS = 4'b1011;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", N, 32'h0);
    @(posedge clk);
    #1;
    check("reset_edge_hold", N, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("release_hold", N, 32'h0);
    @(posedge clk);
    #1;
    check("release_follow", N, 32'h0000_0013);

    // Sweep every IS code with random operands and compare with the model.
    for (int c = 0; c < 16; c++) begin
      for (int rep = 0; rep < 4; rep++) begin
        rr = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
        ii = 22'($urandom_range(0, 22'h3FFFFF));
        drive(rr, ii, 4'(c), ref_sel(rr, ii, 4'(c)));
        sample($sformatf("sweep_is%b", 4'(c)));
        check($sformatf("nox_is%b", 4'(c)), {31'b0, $isunknown(N)}, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/source_operand.md
SOURCE_OPERAND -- requirements
Module: source_operand

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port R, input, 32 bits: register-file operand (rs2 value).
REQ-005 Port Imm, input, 22 bits: immediate field (Imm[21:0] = imm22, Imm[12:0] = simm13, Imm[4:0] = shift count).
REQ-006 Port IS, input, 4 bits: operand-select code from the control unit.
REQ-007 Port N, output, 32 bits: registered second source operand.

Function
REQ-008 The block SHALL form the next operand combinationally from R, Imm and IS, and SHALL register it into N on every rising clk edge while rst_n = 1.
REQ-009 Latency SHALL be exactly one clock: N after edge k equals the selection of the R, Imm and IS values sampled at edge k.
REQ-010 There SHALL be no enable, handshake, or FSM; N updates every cycle.
REQ-011 Selection (don't-care bits marked x):
- IS = 00xx: N = {Imm[21:0], 10'b0} (SETHI form).
- IS = 01xx: N = Imm[21:0] sign-extended with Imm[21] to 32 bits (disp22).
- IS = 1000: N = R.
- IS = 1001: N = Imm[12:0] sign-extended with Imm[12] to 32 bits (simm13).
- IS = 1010: N = {27'b0, R[4:0]}.
- IS = 1011: N = {27'b0, Imm[4:0]}.
- IS = 11x0: N = R.
- IS = 11x1: N = Imm[12:0] sign-extended with Imm[12].
REQ-012 Every one of the 16 IS codes SHALL map to one of the cases above; no code SHALL yield X or hold the previous value.
REQ-013 Sign extension SHALL copy only the named sign bit. Imm[21:13] SHALL NOT affect the simm13 cases. Imm bits above [4] and R bits above [4] SHALL NOT affect the shift-count cases.
REQ-014 X or Z inputs are outside the contract; the block SHALL NOT add any internal resolution for them.

Reset
REQ-015 While rst_n = 0, N SHALL be 32'h00000000, asynchronously and independent of clk.
REQ-016 After rst_n rises, N SHALL hold 0 until the first rising clk edge, then follow REQ-009.
REQ-017 If rst_n is asserted mid-operation, N SHALL clear immediately, and the pending selection SHALL be discarded.

Verification
REQ-018 The bench SHALL cover these scenarios, checking each result one cycle after stimulus:
- R=32'hE0000003, Imm=22'h231113, IS=0000..0011 -> N=32'h8C444C00. With IS=0100..0111 -> N=32'hFFE31113.
- Same inputs, IS=1000 and IS=1100/1110 -> N=32'hE0000003. IS=1001/1101/1111 -> N=32'hFFFFF113. IS=1010 -> 32'h00000003. IS=1011 -> 32'h00000013.
- Imm=22'h230113 (Imm[12]=0), IS=1001/1101/1111 -> N=32'h00000113. IS=1011 -> 32'h00000013. IS=1000 -> 32'hE0000003.
- Latency: change IS from 1000 to 1011 at edge k -> N=32'hE0000003 until edge k, then 32'h00000013 after edge k.
- Reset: drive rst_n=0 between clock edges while N=32'h8C444C00 -> N=0 immediately. Release rst_n -> N stays 0 until the next edge, then reflects the inputs.
- Sweep all 16 IS codes with random R and Imm, compare against a reference model, and confirm no X ever appears on N.
